xconnect_pipe: RTL and testbench
================================

Name: xconnect_pipe

Overview:
Pipelined, flow-controlled successor to the PE butterfly exchange network. It moves one word per PE per beat through NOF_LEVELS butterfly levels. The exchange pattern is selected per beat by a phase counter, so over g beats every PE in a group of size g receives the word of every group member. It adds valid/ready handshakes, configurable pipeline registers, a latched and checked group configuration, and a phase tag travelling with each beat.

Parameters:
WORD_SIZE, 256, bits per PE word
NOF_PES, 16, PE count; power of two, >=2
NOF_LEVELS, $clog2(NOF_PES), butterfly levels
GROUP_SIZE_WIDTH, NOF_LEVELS+1, width of one group-size field
PIPE_MASK, 0, NOF_LEVELS bits; bit l=1 inserts a register after level l; bit NOF_LEVELS-1 ignored (output register always present)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_valid  in  1  config offered
cfg_ready  out  1  config accepted (IDLE only)
groups_sizes  in  GROUP_SIZE_WIDTH*NOF_PES  group size of PE p at [GROUP_SIZE_WIDTH*p +: GROUP_SIZE_WIDTH]
cfg_error  out  1  last offered config rejected
stop  in  1  end of run request (RUN only)
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted
input_pes_data  in  WORD_SIZE*NOF_PES  PE p word at [WORD_SIZE*p +: WORD_SIZE]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
output_pes_data  out  WORD_SIZE*NOF_PES  permuted words, same packing
out_phase  out  NOF_LEVELS  phase tag of the output beat
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE; all stage valids=0; out_valid=0; output_pes_data=0; out_phase=0; cfg_error=0; phase=0.
- FSM IDLE/RUN/DRAIN. cfg_ready=(state==IDLE).
- IDLE: on cfg_valid, latch groups_sizes and check it. Valid config means every g_p is a power of two in 1..NOF_PES, and all PEs in the aligned block [p & ~(g_p-1), +g_p) hold equal g.
  - Valid: cfg_error=0, phase=0, go to RUN.
  - Invalid: cfg_error=1, stay IDLE.
  - cfg_error is held until the next cfg_valid.
- RUN: beats are accepted; stop -> DRAIN. A beat accepted in the same cycle as stop is still processed.
- DRAIN: in_ready=0. Go to IDLE once all stage valids and out_valid are 0 (and the final out beat has been taken).
- Global advance enable: en = !out_valid || out_ready. All pipeline registers load only when en=1, so one stall point covers the whole pipeline.
- in_ready = (state==RUN) && en.
- Accepted beat (in_valid && in_ready): captured with tag phase, then phase <= phase+1 (mod NOF_PES, wraps NOF_PES-1 -> 0).
- Permutation: output PE i receives the input word of PE i XOR (tag & (g_i-1)).
  - Level l (distance 2^l): PE i takes the word from i^2^l iff bit l of (tag & (g_i-1)) is 1; otherwise it keeps its own.
  - Each level uses the tag carried in its own stage, never the live counter.
- Latency: accepted beat appears at out_valid after 1+popcount(PIPE_MASK[NOF_LEVELS-2:0]) cycles with no stall. Throughput is one beat/cycle.
- Beats are never dropped, duplicated or reordered. output_pes_data and out_phase are held stable while out_valid && !out_ready.
- g=1 everywhere: identity every beat. g=NOF_PES: full XOR exchange.
- cfg_valid outside IDLE is ignored. stop outside RUN is ignored.

Decomposition:
- xconnect_pkg holds the config check function (power-of-two and alignment) and a popcount function for latency.
- Sub-module xconnect_stage: one butterfly level with LEVEL and REGISTERED parameters. It carries data, valid and tag, with en as the load strobe. The top instantiates NOF_LEVELS of them in a generate loop.

Test Plan:
All scenarios use NOF_PES=4, WORD_SIZE=8, PIPE_MASK=0 unless stated; inputs A0..A3 = 0x10..0x13.
1. g={4,4,4,4}, four beats -> phase 0: 10,11,12,13; phase 1: 11,10,13,12; phase 2: 12,13,10,11; phase 3: 13,12,11,10; out_phase 0..3; each 1 cycle after acceptance.
2. g={2,2,2,2}, phases 0..3 -> beats 0 and 2 identity; beats 1 and 3 give 11,10,13,12. Fifth beat wraps to phase 0.
3. g={2,4,4,4} -> cfg_error=1, stays IDLE, busy=0. Then g={1,1,2,2} -> cfg_error=0, RUN; phase 1 gives 10,11,13,12.
4. PIPE_MASK=2'b01, out_ready low 3 cycles mid-stream -> latency 2; in_ready=0 during stall; output words held; no beat lost; tags stay contiguous.
5. stop with a beat accepted the same cycle -> that beat is delivered, state DRAIN; IDLE the cycle after the last out handshake; cfg_ready=1.
6. rst pulse mid-RUN with two beats in flight -> out_valid=0 and busy=0 without waiting for clk; no stale beat appears after a new config.

Source files
------------

// File: rtl/xconnect_pkg.sv
`default_nettype none
// ============================================================================
// xconnect_pkg
// Shared state encoding and group-configuration helpers for xconnect_pipe.
// Revision: 1.0
// ============================================================================
package xconnect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Group size must be a power of two no larger than the PE count.
  function automatic logic size_ok(input int g, input int n);
    return (g >= 1) && (g <= n) && ((g & (g - 1)) == 0);
  endfunction

  function automatic int block_base(input int p, input int g);
    return p & ~(g - 1);
  endfunction

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xconnect_if.sv
`default_nettype none
// ============================================================================
// xconnect_if
// Config, input-beat and output-beat handshake bundle of xconnect_pipe.
// Revision: 1.0
// ============================================================================
interface xconnect_if #(
  parameter int WORD_SIZE        = 256,
  parameter int NOF_PES          = 16,
  parameter int NOF_LEVELS       = $clog2(NOF_PES),
  parameter int GROUP_SIZE_WIDTH = NOF_LEVELS + 1
);
  logic                                  cfg_valid;
  logic                                  cfg_ready;
  logic [GROUP_SIZE_WIDTH*NOF_PES-1:0]   groups_sizes;
  logic                                  cfg_error;
  logic                                  stop;
  logic                                  in_valid;
  logic                                  in_ready;
  logic [WORD_SIZE*NOF_PES-1:0]          input_pes_data;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [WORD_SIZE*NOF_PES-1:0]          output_pes_data;
  logic [NOF_LEVELS-1:0]                 out_phase;
  logic                                  busy;

  modport slave (
    input  cfg_valid, groups_sizes, stop, in_valid, input_pes_data, out_ready,
    output cfg_ready, cfg_error, in_ready, out_valid, output_pes_data, out_phase, busy
  );

  modport master (
    output cfg_valid, groups_sizes, stop, in_valid, input_pes_data, out_ready,
    input  cfg_ready, cfg_error, in_ready, out_valid, output_pes_data, out_phase, busy
  );
endinterface
`default_nettype wire

// File: rtl/xconnect_stage.sv
`default_nettype none
// ============================================================================
// xconnect_stage
// One butterfly level: PE i optionally swaps with PE i^2^LEVEL, then an
// optional register stage loaded by the global advance enable.
// Revision: 1.0
// ============================================================================
module xconnect_stage #(
  parameter int WORD_SIZE  = 256,
  parameter int NOF_PES    = 16,
  parameter int NOF_LEVELS = 4,
  parameter int LEVEL      = 0,
  parameter bit REGISTERED = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic                           i_valid,
  input  logic [NOF_LEVELS-1:0]          i_tag,
  input  logic [NOF_PES-1:0]             i_sel,
  input  logic [WORD_SIZE*NOF_PES-1:0]   i_data,
  output logic                           o_valid,
  output logic [NOF_LEVELS-1:0]          o_tag,
  output logic [WORD_SIZE*NOF_PES-1:0]   o_data
);

  logic [WORD_SIZE*NOF_PES-1:0] w_data;

  // i_sel[p] is bit LEVEL of PE p's group mask; the tag travels with the beat.
  always_comb begin
    w_data = i_data;
    if (i_tag[LEVEL]) begin
      for (int p = 0; p < NOF_PES; p++) begin
        if (i_sel[p]) begin
          w_data[p*WORD_SIZE +: WORD_SIZE] = i_data[(p ^ (1 << LEVEL))*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

  if (REGISTERED) begin : g_reg
    logic                          r_valid;
    logic [NOF_LEVELS-1:0]         r_tag;
    logic [WORD_SIZE*NOF_PES-1:0]  r_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_tag   <= '0;
        r_data  <= '0;
      end else if (i_en) begin
        r_valid <= i_valid;
        r_tag   <= i_tag;
        r_data  <= w_data;
      end
    end

    assign o_valid = r_valid;
    assign o_tag   = r_tag;
    assign o_data  = r_data;
  end else begin : g_comb
    logic w_unused;
    assign w_unused = ^{clk, rst, i_en};
    assign o_valid  = i_valid;
    assign o_tag    = i_tag;
    assign o_data   = w_data;
  end

endmodule
`default_nettype wire

// File: rtl/xconnect_pipe.sv
`default_nettype none
// ============================================================================
// xconnect_pipe
// Flow-controlled pipelined butterfly exchange with checked group config.
// Revision: 1.0
// ============================================================================
module xconnect_pipe
  import xconnect_pkg::*;
#(
  parameter int                    WORD_SIZE        = 256,
  parameter int                    NOF_PES          = 16,
  parameter int                    NOF_LEVELS       = $clog2(NOF_PES),
  parameter int                    GROUP_SIZE_WIDTH = NOF_LEVELS + 1,
  parameter logic [NOF_LEVELS-1:0] PIPE_MASK        = '0
) (
  input  logic      clk,
  input  logic      rst,
  xconnect_if.slave io_bus
);

  localparam int c_GW = GROUP_SIZE_WIDTH * NOF_PES;

  state_t                         r_state;
  state_t                         w_state_next;
  logic [c_GW-1:0]                r_groups;
  logic                           r_cfg_error;
  logic [NOF_LEVELS-1:0]          r_phase;
  logic                           w_en;
  logic                           w_in_ready;
  logic                           w_accept;
  logic                           w_cfg_take;
  logic                           w_cfg_ok;
  logic                           w_inflight;
  logic [NOF_LEVELS-1:0]          w_stage_valid;
  logic [NOF_PES*NOF_LEVELS-1:0]  w_gmask;

  // A single stall point: the whole pipe advances only when the output can move.
  assign w_en       = !w_stage_valid[NOF_LEVELS-1] || io_bus.out_ready;
  assign w_in_ready = (r_state == ST_RUN) && w_en;
  assign w_accept   = io_bus.in_valid && w_in_ready;
  assign w_cfg_take = (r_state == ST_IDLE) && io_bus.cfg_valid;

  always_comb begin
    w_cfg_ok = 1'b1;
    for (int p = 0; p < NOF_PES; p++) begin
      int gp;
      gp = int'(io_bus.groups_sizes[p*GROUP_SIZE_WIDTH +: GROUP_SIZE_WIDTH]);
      if (!size_ok(gp, NOF_PES)) begin
        w_cfg_ok = 1'b0;
      end else begin
        for (int q = 0; q < NOF_PES; q++) begin
          if ((block_base(q, gp) == block_base(p, gp)) &&
              (int'(io_bus.groups_sizes[q*GROUP_SIZE_WIDTH +: GROUP_SIZE_WIDTH]) != gp)) begin
            w_cfg_ok = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_cfg_take && w_cfg_ok) w_state_next = ST_RUN;
      ST_RUN:   if (io_bus.stop) w_state_next = ST_DRAIN;
      ST_DRAIN: if (!w_inflight && w_en) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_groups    <= '0;
      r_cfg_error <= 1'b0;
      r_phase     <= '0;
    end else if (w_cfg_take) begin
      r_groups    <= io_bus.groups_sizes;
      r_cfg_error <= !w_cfg_ok;
      if (w_cfg_ok) r_phase <= '0;
    end else if (w_accept) begin
      r_phase <= r_phase + 1'b1;
    end
  end

  for (genvar p = 0; p < NOF_PES; p++) begin : g_pe_mask
    assign w_gmask[p*NOF_LEVELS +: NOF_LEVELS] =
      NOF_LEVELS'(r_groups[p*GROUP_SIZE_WIDTH +: GROUP_SIZE_WIDTH] - 1'b1);
  end

  for (genvar l = 0; l < NOF_LEVELS; l++) begin : g_lvl
    logic                           w_vi;
    logic [NOF_LEVELS-1:0]          w_ti;
    logic [WORD_SIZE*NOF_PES-1:0]   w_di;
    logic                           w_vo;
    logic [NOF_LEVELS-1:0]          w_to;
    logic [WORD_SIZE*NOF_PES-1:0]   w_do;
    logic [NOF_PES-1:0]             w_sel;

    if (l == 0) begin : g_first
      assign w_vi = w_accept;
      assign w_ti = r_phase;
      assign w_di = io_bus.input_pes_data;
    end else begin : g_next
      assign w_vi = g_lvl[l-1].w_vo;
      assign w_ti = g_lvl[l-1].w_to;
      assign w_di = g_lvl[l-1].w_do;
    end

    for (genvar p = 0; p < NOF_PES; p++) begin : g_sel
      assign w_sel[p] = w_gmask[p*NOF_LEVELS + l];
    end

    xconnect_stage #(
      .WORD_SIZE  (WORD_SIZE),
      .NOF_PES    (NOF_PES),
      .NOF_LEVELS (NOF_LEVELS),
      .LEVEL      (l),
      .REGISTERED ((l == NOF_LEVELS-1) ? 1'b1 : PIPE_MASK[l])
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en),
      .i_valid (w_vi),
      .i_tag   (w_ti),
      .i_sel   (w_sel),
      .i_data  (w_di),
      .o_valid (w_vo),
      .o_tag   (w_to),
      .o_data  (w_do)
    );

    assign w_stage_valid[l] = w_vo;
  end

  // Everything but the output register; the output handshake is covered by w_en.
  always_comb begin
    w_inflight = 1'b0;
    for (int l = 0; l < NOF_LEVELS-1; l++) begin
      w_inflight = w_inflight | w_stage_valid[l];
    end
  end

  assign io_bus.cfg_ready       = (r_state == ST_IDLE);
  assign io_bus.cfg_error       = r_cfg_error;
  assign io_bus.in_ready        = w_in_ready;
  assign io_bus.out_valid       = w_stage_valid[NOF_LEVELS-1];
  assign io_bus.output_pes_data = g_lvl[NOF_LEVELS-1].w_do;
  assign io_bus.out_phase       = g_lvl[NOF_LEVELS-1].w_to;
  assign io_bus.busy            = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_xconnect_pipe.sv
`default_nettype none
// ============================================================================
// tb_xconnect_pipe
// Directed checks of xconnect_pipe with 4 PEs of 8-bit words.
// Revision: 1.0
// ============================================================================
module tb_xconnect_pipe;
  import xconnect_pkg::*;

  localparam int         c_W     = 8;
  localparam int         c_N     = 4;
  localparam logic [1:0] c_MASK1 = 2'b01;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;
  int   lat1;
  int   sent;
  int   recv;
  logic acc;
  logic hs;
  logic [31:0] exp4 [4];

  always #5 clk = ~clk;

  xconnect_if #(.WORD_SIZE(c_W), .NOF_PES(c_N)) bus0 ();
  xconnect_if #(.WORD_SIZE(c_W), .NOF_PES(c_N)) bus1 ();

  xconnect_pipe #(.WORD_SIZE(c_W), .NOF_PES(c_N), .PIPE_MASK(2'b00)) dut0 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus0.slave)
  );

  xconnect_pipe #(.WORD_SIZE(c_W), .NOF_PES(c_N), .PIPE_MASK(c_MASK1)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus1.slave)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg0(input logic [11:0] g);
    bus0.cfg_valid    = 1'b1;
    bus0.groups_sizes = g;
    step();
    bus0.cfg_valid    = 1'b0;
  endtask

  task automatic send0(input logic [31:0] d);
    bus0.in_valid       = 1'b1;
    bus0.input_pes_data = d;
    bus0.out_ready      = 1'b1;
    step();
    bus0.in_valid       = 1'b0;
  endtask

  task automatic stop0();
    bus0.stop = 1'b1;
    step();
    bus0.stop = 1'b0;
    for (int k = 0; k < 10 && bus0.busy; k++) step();
    chk("drain_idle0", bus0.busy, 1'b0);
  endtask

  initial begin
    exp4 = '{32'h13121110, 32'h12131011, 32'h11101312, 32'h10111213};
    lat1 = 1 + popcount(32'(c_MASK1));
    bus0.cfg_valid = 1'b0; bus0.groups_sizes = '0; bus0.stop = 1'b0;
    bus0.in_valid = 1'b0; bus0.input_pes_data = '0; bus0.out_ready = 1'b1;
    bus1.cfg_valid = 1'b0; bus1.groups_sizes = '0; bus1.stop = 1'b0;
    bus1.in_valid = 1'b0; bus1.input_pes_data = '0; bus1.out_ready = 1'b1;

    // reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", bus0.out_valid, 1'b0);
    chk("rst_busy", bus0.busy, 1'b0);
    chk("rst_cfg_ready", bus0.cfg_ready, 1'b1);
    chk("rst_cfg_error", bus0.cfg_error, 1'b0);
    chk("rst_out_data", bus0.output_pes_data, 32'h0);
    chk("rst_out_phase", bus0.out_phase, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // full group: all four exchange patterns
    cfg0(12'h924);
    chk("t1_busy", bus0.busy, 1'b1);
    chk("t1_cfg_err", bus0.cfg_error, 1'b0);
    chk("t1_cfg_ready", bus0.cfg_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      send0(32'h13121110);
      chk($sformatf("t1_valid%0d", k), bus0.out_valid, 1'b1);
      chk($sformatf("t1_data%0d", k), bus0.output_pes_data, exp4[k]);
      chk($sformatf("t1_phase%0d", k), bus0.out_phase, 64'(k));
    end
    step();
    chk("t1_empty", bus0.out_valid, 1'b0);
    stop0();

    // pairs, with phase wrap on the fifth beat
    cfg0(12'h492);
    for (int k = 0; k < 5; k++) begin
      send0(32'h13121110);
      chk($sformatf("t2_data%0d", k), bus0.output_pes_data,
          (k % 2 == 1) ? 32'h12131011 : 32'h13121110);
      chk($sformatf("t2_phase%0d", k), bus0.out_phase, 64'(k % 4));
    end
    stop0();

    // rejected then accepted config
    cfg0(12'h922);
    chk("t3_err", bus0.cfg_error, 1'b1);
    chk("t3_busy", bus0.busy, 1'b0);
    chk("t3_cfg_ready", bus0.cfg_ready, 1'b1);
    cfg0(12'h489);
    chk("t3_err_clr", bus0.cfg_error, 1'b0);
    chk("t3_run", bus0.busy, 1'b1);
    send0(32'h13121110);
    chk("t3_ph0", bus0.output_pes_data, 32'h13121110);
    send0(32'h13121110);
    chk("t3_ph1", bus0.output_pes_data, 32'h12131110);
    stop0();

    // extra register after level 0, stall mid-stream
    bus1.cfg_valid = 1'b1; bus1.groups_sizes = 12'h924;
    step();
    bus1.cfg_valid = 1'b0;
    chk("t4_busy", bus1.busy, 1'b1);
    sent = 0; recv = 0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      bus1.in_valid       = (sent < 8);
      bus1.input_pes_data = 32'h13121110;
      bus1.out_ready      = !(c >= 4 && c <= 6);
      #1;
      if (c == lat1 - 1) chk("t4_lat_lo", bus1.out_valid, 1'b0);
      if (c == lat1)     chk("t4_lat_hi", bus1.out_valid, 1'b1);
      acc = bus1.in_valid && bus1.in_ready;
      hs  = bus1.out_valid && bus1.out_ready;
      if (bus1.out_valid) begin
        chk("t4_data", bus1.output_pes_data, exp4[recv % 4]);
        chk("t4_phase", bus1.out_phase, 64'(recv % 4));
      end
      if (bus1.out_valid && !bus1.out_ready) chk("t4_stall_in_ready", bus1.in_ready, 1'b0);
      step();
      if (acc) sent++;
      if (hs) recv++;
    end
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b1;
    chk("t4_recv", 64'(recv), 64'd8);
    chk("t4_sent", 64'(sent), 64'd8);
    bus1.stop = 1'b1;
    step();
    bus1.stop = 1'b0;
    for (int k = 0; k < 10 && bus1.busy; k++) step();
    chk("t4_idle", bus1.busy, 1'b0);

    // stop together with an accepted beat
    cfg0(12'h924);
    bus0.in_valid = 1'b1; bus0.stop = 1'b1; bus0.out_ready = 1'b0;
    bus0.input_pes_data = 32'h13121110;
    step();
    bus0.in_valid = 1'b0; bus0.stop = 1'b0;
    chk("t5_valid", bus0.out_valid, 1'b1);
    chk("t5_data", bus0.output_pes_data, 32'h13121110);
    chk("t5_busy", bus0.busy, 1'b1);
    chk("t5_in_ready", bus0.in_ready, 1'b0);
    step();
    chk("t5_hold_valid", bus0.out_valid, 1'b1);
    chk("t5_hold_data", bus0.output_pes_data, 32'h13121110);
    chk("t5_hold_busy", bus0.busy, 1'b1);
    bus0.out_ready = 1'b1;
    step();
    chk("t5_idle", bus0.busy, 1'b0);
    chk("t5_cfg_ready", bus0.cfg_ready, 1'b1);
    chk("t5_out_empty", bus0.out_valid, 1'b0);

    // asynchronous reset with a beat in flight
    cfg0(12'h924);
    bus0.in_valid = 1'b1; bus0.out_ready = 1'b0;
    bus0.input_pes_data = 32'hA3A2A1A0;
    step();
    chk("t6_pre_valid", bus0.out_valid, 1'b1);
    bus0.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", bus0.out_valid, 1'b0);
    chk("t6_rst_busy", bus0.busy, 1'b0);
    chk("t6_rst_data", bus0.output_pes_data, 32'h0);
    #1 rst = 1'b0;
    step();
    cfg0(12'h924);
    bus0.out_ready = 1'b1;
    step();
    chk("t6_no_stale0", bus0.out_valid, 1'b0);
    step();
    chk("t6_no_stale1", bus0.out_valid, 1'b0);
    send0(32'hA3A2A1A0);
    chk("t6_data", bus0.output_pes_data, 32'hA3A2A1A0);
    chk("t6_phase", bus0.out_phase, 2'd0);
    stop0();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
